// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage: issues in-order fetches over valid/ready, buffers up to DEPTH
// in-flight/returned words, and feeds Decode through a stallable, flushable IF/ID register.
module fetch_queue_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ILEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            StallD,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic [ILEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW:0] DEPTH_CNT = (PW+1)'(DEPTH);

  typedef logic [PW-1:0] ptr_t;

  logic [XLEN-1:0] pcf;
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [ILEN-1:0] q_instr [DEPTH];
  logic [DEPTH-1:0] q_filled;

  ptr_t alloc_ptr, fill_ptr, rd_ptr, drop_cnt;
  ptr_t occ, unfilled, stale_sum, redirect_drop;
  logic [PW:0] budget_used;
  logic [AW-1:0] alloc_idx, fill_idx, rd_idx;
  logic req_fire, rsp_drop, rsp_fill, pop;

  // Pointers carry one extra wrap bit so occ can reach DEPTH.
  assign occ         = alloc_ptr - rd_ptr;
  assign unfilled    = alloc_ptr - fill_ptr;
  assign budget_used = {1'b0, occ} + {1'b0, drop_cnt};
  assign alloc_idx   = alloc_ptr[AW-1:0];
  assign fill_idx    = fill_ptr[AW-1:0];
  assign rd_idx      = rd_ptr[AW-1:0];

  // Responses still owed by the memory count against the budget, so stale words never overrun it.
  assign imem_req_valid = !rst && !PCSrcE && (budget_used < DEPTH_CNT);
  assign imem_req_addr  = pcf;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_drop = imem_rsp_valid && !PCSrcE && (drop_cnt != '0);
  assign rsp_fill = imem_rsp_valid && !PCSrcE && (drop_cnt == '0) && (unfilled != '0);
  assign pop      = !PCSrcE && !StallD && (occ != '0) && q_filled[rd_idx];

  // A response landing in the redirect cycle is itself one of the stale words.
  assign stale_sum     = drop_cnt + unfilled;
  assign redirect_drop = (imem_rsp_valid && stale_sum != '0) ? stale_sum - ptr_t'(1) : stale_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcf       <= RESET_PC;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      drop_cnt  <= '0;
      q_filled  <= '0;
    end else if (PCSrcE) begin
      pcf      <= PCTargetE;
      rd_ptr   <= alloc_ptr;
      fill_ptr <= alloc_ptr;
      q_filled <= '0;
      drop_cnt <= redirect_drop;
    end else begin
      if (req_fire) begin
        pcf                 <= pcf + XLEN'(4);
        alloc_ptr           <= alloc_ptr + ptr_t'(1);
        q_filled[alloc_idx] <= 1'b0;
      end
      if (rsp_drop) drop_cnt <= drop_cnt - ptr_t'(1);
      if (rsp_fill) begin
        fill_ptr           <= fill_ptr + ptr_t'(1);
        q_filled[fill_idx] <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + ptr_t'(1);
    end
  end

  // NOTE: payload arrays carry no reset; an entry is only read once its filled bit, which is reset, says so.
  always_ff @(posedge clk) begin
    if (req_fire) q_pc[alloc_idx]   <= pcf;
    if (rsp_fill) q_instr[fill_idx] <= imem_rsp_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      InstrD   <= '0;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (PCSrcE) begin
      InstrD <= '0;
      ValidD <= 1'b0;
    end else if (!StallD) begin
      if (pop) begin
        InstrD   <= q_instr[rd_idx];
        PCD      <= q_pc[rd_idx];
        PCPlus4D <= q_pc[rd_idx] + XLEN'(4);
        ValidD   <= 1'b1;
      end else begin
        InstrD <= '0;
        ValidD <= 1'b0;
      end
    end
  end

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && drop_cnt == '0 && unfilled == '0));

  a_drop_bounded: assert property (@(posedge clk) disable iff (rst)
    {1'b0, drop_cnt} <= DEPTH_CNT);

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Scoreboard bench for fetch_queue_stage: an in-order variable-latency memory model feeds the DUT,
// fetched PCs are queued as they are requested and compared when they reach Decode.
module tb_fetch_queue_stage;

  localparam int XLEN  = 32;
  localparam int ILEN  = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            PCSrcE = 1'b0;
  logic [XLEN-1:0] PCTargetE = '0;
  logic            StallD = 1'b0;
  logic            imem_req_valid;
  logic            imem_req_ready = 1'b0;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid = 1'b0;
  logic [ILEN-1:0] imem_rsp_data = '0;
  logic [ILEN-1:0] InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic            ValidD;

  fetch_queue_stage #(
    .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  mem_req_t    pending[$];
  logic [31:0] sb_pc[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] model_pc = RESET_PC;
  logic        new_valid = 1'b0;
  logic        last_req_valid = 1'b0;
  logic [31:0] last_req_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h00A0_0093 + a;
  endfunction

  // One clock cycle: sample the request side, let the edge happen, check Decode, then drive the memory.
  task automatic step();
    logic        hs, was_redirect, was_stall, v_q;
    logic [31:0] addr_s, tgt_s, instr_q, pc_q, pc4_q, exp_pc;
    #1;
    hs             = imem_req_valid && imem_req_ready;
    last_req_valid = imem_req_valid;
    last_req_addr  = imem_req_addr;
    addr_s         = imem_req_addr;
    if (imem_req_valid === 1'b1) begin
      vectors++;
      if (imem_req_addr !== model_pc) begin
        miscompares++;
        $display("FAIL req_addr: got %h expected %h", imem_req_addr, model_pc);
      end
    end
    v_q = ValidD; instr_q = InstrD; pc_q = PCD; pc4_q = PCPlus4D;
    was_redirect = PCSrcE; was_stall = StallD; tgt_s = PCTargetE;
    @(posedge clk);
    cyc++;
    if (was_redirect) begin
      sb_pc.delete();
      model_pc = tgt_s;
    end else if (hs) begin
      sb_pc.push_back(model_pc);
      model_pc += 32'd4;
      pending.push_back('{addr: addr_s, due: cyc - 1 + lat});
    end
    #1;
    new_valid = 1'b0;
    vectors++;
    if (was_redirect) begin
      if (ValidD !== 1'b0 || InstrD !== '0) begin
        miscompares++;
        $display("FAIL redirect_kill: got v=%b instr=%h expected v=0 instr=0", ValidD, InstrD);
      end
    end else if (was_stall) begin
      if (ValidD !== v_q || InstrD !== instr_q || PCD !== pc_q || PCPlus4D !== pc4_q) begin
        miscompares++;
        $display("FAIL stall_hold: got v=%b instr=%h pc=%h expected v=%b instr=%h pc=%h",
                 ValidD, InstrD, PCD, v_q, instr_q, pc_q);
      end
    end else if (ValidD === 1'b1) begin
      new_valid = 1'b1;
      if (sb_pc.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_instr: got pc=%h instr=%h expected no instruction", PCD, InstrD);
      end else begin
        exp_pc = sb_pc.pop_front();
        if (PCD !== exp_pc || InstrD !== mem_word(exp_pc) || PCPlus4D !== exp_pc + 32'd4) begin
          miscompares++;
          $display("FAIL decode_out: got pc=%h instr=%h pc4=%h expected pc=%h instr=%h pc4=%h",
                   PCD, InstrD, PCPlus4D, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
        end
      end
    end else begin
      if (InstrD !== '0 || PCD !== pc_q || PCPlus4D !== pc4_q) begin
        miscompares++;
        $display("FAIL bubble: got instr=%h pc=%h expected instr=0 pc=%h", InstrD, PCD, pc_q);
      end
    end
    @(negedge clk);
    if (pending.size() != 0 && pending[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pending[0].addr);
      void'(pending.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic drain();
    imem_req_ready = 1'b0;
    StallD = 1'b0;
    PCSrcE = 1'b0;
    for (int i = 0; i < 40 && (sb_pc.size() != 0 || pending.size() != 0); i++) step();
    vectors++;
    if (sb_pc.size() != 0 || pending.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d undelivered, %0d unanswered expected 0, 0", sb_pc.size(), pending.size());
    end
  endtask

  task automatic redirect_to(input logic [31:0] target);
    imem_req_ready = 1'b0;
    PCSrcE = 1'b1;
    PCTargetE = target;
    step();
    PCSrcE = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (ValidD !== 1'b0 || InstrD !== '0 || PCD !== '0 || PCPlus4D !== '0 || imem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b instr=%h pc=%h pc4=%h req=%b expected all 0",
               ValidD, InstrD, PCD, PCPlus4D, imem_req_valid);
    end
    @(negedge clk);
    @(negedge clk);
    model_pc = RESET_PC;
    rst = 1'b0;
  endtask

  task automatic test_stream();
    lat = 1;
    StallD = 1'b0;
    imem_req_ready = 1'b1;
    for (int j = 0; j < 9; j++) begin
      step();
      if (j == 0) begin
        vectors++;
        if (last_req_valid !== 1'b1 || last_req_addr !== RESET_PC) begin
          miscompares++;
          $display("FAIL first_req: got v=%b addr=%h expected v=1 addr=%h", last_req_valid, last_req_addr, RESET_PC);
        end
      end
      vectors++;
      if (ValidD !== (j + 1 >= 3)) begin
        miscompares++;
        $display("FAIL latency_valid: cycle %0d got %b expected %b", j + 1, ValidD, (j + 1 >= 3));
      end
      if (j == 2) begin
        vectors++;
        if (PCD !== 32'h0 || PCPlus4D !== 32'h4 || InstrD !== 32'h00A0_0093) begin
          miscompares++;
          $display("FAIL first_instr: got pc=%h pc4=%h instr=%h expected 0 4 00a00093", PCD, PCPlus4D, InstrD);
        end
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) step();
    StallD = 1'b1;
    for (int i = 0; i < 3; i++) step();
    vectors++;
    if (last_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL full_req_valid: got %b expected 0", last_req_valid);
    end
    StallD = 1'b0;
    for (int i = 0; i < 4; i++) step();
    drain();
  endtask

  task automatic test_redirect();
    logic got;
    lat = 3;
    StallD = 1'b0;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      step();
      got = ValidD;
    end
    vectors++;
    if (got !== 1'b1) begin
      miscompares++;
      $display("FAIL redirect_setup: got ValidD=%b expected 1 within 12 cycles", got);
    end
    StallD = 1'b1;
    imem_req_ready = 1'b1;
    step();
    step();
    PCSrcE = 1'b1;
    PCTargetE = 32'h0000_0100;
    imem_req_ready = 1'b0;
    step();
    PCSrcE = 1'b0;
    vectors++;
    if (last_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL redirect_no_req: got %b expected 0", last_req_valid);
    end
    StallD = 1'b0;
    imem_req_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = new_valid;
    end
    vectors++;
    if (got !== 1'b1 || PCD !== 32'h0000_0100) begin
      miscompares++;
      $display("FAIL redirect_target: got valid=%b pc=%h expected valid=1 pc=00000100", got, PCD);
    end
    drain();
  endtask

  task automatic test_ready_toggle();
    logic pat [6];
    pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    lat = 1;
    redirect_to(32'h0000_0040);
    for (int i = 0; i < 6; i++) begin
      imem_req_ready = pat[i];
      step();
      if (i < 2) begin
        vectors++;
        if (last_req_valid !== 1'b1 || last_req_addr !== 32'h0000_0040) begin
          miscompares++;
          $display("FAIL addr_hold: got v=%b addr=%h expected v=1 addr=00000040", last_req_valid, last_req_addr);
        end
      end
      if (i == 3) begin
        vectors++;
        if (last_req_addr !== 32'h0000_0044) begin
          miscompares++;
          $display("FAIL addr_advance: got %h expected 00000044", last_req_addr);
        end
      end
    end
    drain();
  endtask

  task automatic test_wrap();
    logic [31:0] seen_pc [3];
    logic [31:0] seen_p4 [3];
    int n;
    lat = 1;
    redirect_to(32'hFFFF_FFF8);
    imem_req_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 15 && n < 3; i++) begin
      step();
      if (new_valid) begin
        seen_pc[n] = PCD;
        seen_p4[n] = PCPlus4D;
        n++;
      end
    end
    vectors++;
    if (n != 3 || seen_pc[0] !== 32'hFFFF_FFF8 || seen_pc[1] !== 32'hFFFF_FFFC || seen_pc[2] !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_seq: got n=%0d %h %h %h expected 3 fffffff8 fffffffc 00000000",
               n, seen_pc[0], seen_pc[1], seen_pc[2]);
    end
    vectors++;
    if (seen_p4[1] !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_pc4: got %h expected 00000000", seen_p4[1]);
    end
    drain();
  endtask

  task automatic test_async_reset();
    logic got;
    lat = 6;
    StallD = 1'b0;
    imem_req_ready = 1'b1;
    step();
    redirect_to(32'h0000_0200);
    StallD = 1'b1;
    imem_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    imem_req_ready = 1'b0;
    #1;
    vectors++;
    if (imem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL full_with_drop: got %b expected 0", imem_req_valid);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (ValidD !== 1'b0 || InstrD !== '0 || PCD !== '0 || PCPlus4D !== '0 || imem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got v=%b instr=%h pc=%h pc4=%h req=%b expected all 0",
               ValidD, InstrD, PCD, PCPlus4D, imem_req_valid);
    end
    pending.delete();
    sb_pc.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    model_pc = RESET_PC;
    @(posedge clk);
    @(negedge clk);
    StallD = 1'b0;
    lat = 1;
    imem_req_ready = 1'b1;
    rst = 1'b0;
    step();
    vectors++;
    if (last_req_valid !== 1'b1 || last_req_addr !== RESET_PC) begin
      miscompares++;
      $display("FAIL restart_req: got v=%b addr=%h expected v=1 addr=%h", last_req_valid, last_req_addr, RESET_PC);
    end
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      got = new_valid;
    end
    vectors++;
    if (got !== 1'b1 || PCD !== RESET_PC) begin
      miscompares++;
      $display("FAIL restart_pc: got valid=%b pc=%h expected valid=1 pc=%h", got, PCD, RESET_PC);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_ready_toggle();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
- Parametrised instruction-fetch stage that decouples the PC generator from a variable-latency instruction memory.
- Issues in-order fetch requests over a valid/ready handshake and buffers up to DEPTH in-flight or returned fetches in a queue.
- Presents the head instruction to Decode through a stallable, flushable IF/ID register.
- Handles Execute-stage redirects (PCSrcE/PCTargetE) by flushing the queue and discarding stale responses still in flight.

Parameters:
- XLEN, 32: PC and address width.
- ILEN, 32: instruction word width.
- DEPTH, 4: queue entries; power of 2, at least 2; also the cap on outstanding plus buffered fetches.
- RESET_PC, 32'h00000000: PCF value after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- PCSrcE  in  1  redirect request from Execute.
- PCTargetE  in  XLEN  redirect target.
- StallD  in  1  Decode stall; holds the IF/ID register.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  XLEN  fetch address (PCF).
- imem_rsp_valid  in  1  response valid; in order; at least 1 cycle after acceptance.
- imem_rsp_data  in  ILEN  response instruction.
- InstrD  out  ILEN  instruction to Decode.
- PCD  out  XLEN  PC of InstrD.
- PCPlus4D  out  XLEN  PCD+4.
- ValidD  out  1  InstrD holds a real instruction.

Behaviour:
- Reset, asynchronous while rst=1:
  - PCF=RESET_PC.
  - Queue empty: alloc, fill and read pointers at 0; all filled bits at 0.
  - drop_cnt=0.
  - InstrD=0, PCD=0, PCPlus4D=0, ValidD=0.
  - imem_req_valid=0.
  - Reset asserted mid-operation discards everything. The memory shares rst, so no stale responses exist afterwards.
- Queue entry fields: pc, instr, filled.
  - occ = allocated entries, counted from the read pointer up to the alloc pointer.
  - unfilled = allocated entries with filled=0.
- Request rule:
  - imem_req_valid = !rst && !PCSrcE && (occ + drop_cnt < DEPTH).
  - imem_req_addr = PCF.
  - On handshake (valid and ready): allocate an entry with pc=PCF, filled=0, and set PCF<=PCF+4.
  - Address arithmetic is modulo 2^XLEN, so PCF=0xFFFFFFFC advances to 0.
  - imem_req_valid may drop without a handshake; addr stays stable while valid is held.
- Response rule:
  - If drop_cnt>0: discard the response and decrement drop_cnt.
  - Otherwise: write instr into the entry at the fill pointer, set filled=1, and advance the fill pointer.
  - A response arriving while unfilled=0 and drop_cnt=0 is a protocol error. Flag it with an assertion; the RTL ignores it.
- IF/ID register, applied when PCSrcE=0:
  - If StallD=1: hold all D outputs; the queue head is not popped.
  - If StallD=0 and the head is filled: load InstrD/PCD from the head, set PCPlus4D=PCD+4 and ValidD=1, and pop the head.
  - If StallD=0 and the head is empty or unfilled: insert a bubble (ValidD=0, InstrD=0, PCD/PCPlus4D hold).
  - Pop and allocate in the same cycle are legal at full occupancy minus one. A response fill and a pop of a different entry in the same cycle are both legal.
- Redirect (PCSrcE=1) takes priority over StallD and over all other events:
  - PCF<=PCTargetE.
  - No request is issued that cycle.
  - Queue cleared: pointers equalised, filled bits cleared.
  - drop_cnt <= drop_cnt + unfilled − (imem_rsp_valid ? 1 : 0). A response arriving in the redirect cycle is itself discarded.
  - ValidD<=0 and InstrD<=0.
- Latency, zero-wait memory with ready=1 and 1-cycle response:
  - Request accepted in cycle t, response in t+1, filled at the end of t+1, ValidD=1 from t+3.
  - No bypass from response to D.
  - Steady-state throughput is 1 instruction/cycle when DEPTH ≥ 2 + response latency.
- Boundary conditions:
  - Full (occ+drop_cnt=DEPTH): imem_req_valid=0.
  - Empty: a bubble is inserted.
  - Back-to-back redirects accumulate drop_cnt correctly.
  - drop_cnt never exceeds DEPTH.

Test Plan:
1. Reset release, RESET_PC=0, ready=1, 1-cycle memory returning 0x00A00093 and successive words -> requests at 0, 4, 8…; ValidD=1 from cycle 3 with PCD=0, PCPlus4D=4; then one instruction per cycle in order.
2. StallD=1 for 3 cycles mid-stream -> D outputs held; the queue fills to DEPTH and imem_req_valid drops; after release, no instruction is lost or duplicated.
3. PCSrcE=1, PCTargetE=0x100, with 2 responses in flight on a 3-cycle memory -> exactly 2 responses discarded; ValidD=0 the next cycle; first valid PCD=0x100.
4. imem_req_ready toggling 1-0-1 with PCF=0x40 -> addr held at 0x40 until handshake; no skipped or duplicated PCs.
5. PCF=0xFFFFFFF8 streaming -> PCD sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0; PCPlus4D of 0xFFFFFFFC is 0x0.
6. rst=1 asynchronously mid-stream with a full queue and drop_cnt=1 -> all outputs return to reset values immediately; after release, fetching restarts at RESET_PC.
